cpu_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the single-cycle MIPS datapath (`cpu`). It latches each fetched instruction, decodes it, and drives the datapath's mux selects, ALU opcode, register-file write strobe and PC enable over 2–4 cycles per instruction. It also runs a request/acknowledge handshake with data memory, traps illegal opcodes and counts retired instructions.

---
 rtl/cpu_ctrl_fsm.sv | 181 ++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS datapath: latches the fetched
// instruction, decodes it and drives selects and strobes over 2-4 cycles.
module cpu_ctrl_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          inst,
  input  logic                 z,
  input  logic                 dmem_ack,
  output logic [31:0]          ir,
  output logic [4:0]           Rsc,
  output logic [4:0]           Rtc,
  output logic [4:0]           Rdc,
  output logic [3:0]           aluc,
  output logic                 M1,
  output logic                 M2,
  output logic                 M3,
  output logic                 M4,
  output logic                 M5,
  output logic                 M6,
  output logic                 M7,
  output logic                 M8,
  output logic                 M9,
  output logic                 RF_W,
  output logic                 sign,
  output logic                 pc_ena,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 illegal,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_TRAP  = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_SHIFT, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR
  } iclass_e;

  state_e                 r_state;
  state_e                 w_next_state;
  logic [31:0]            r_ir;
  logic [INSTRET_W-1:0]   r_instret;
  iclass_e                w_class;
  logic [3:0]             w_aluc;
  logic                   w_sext;
  logic                   w_active;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset branch is synchronous.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ir      <= '0;
      r_instret <= '0;
    end else begin
      if (r_state == S_FETCH) r_ir <= inst;
      if (pc_ena)             r_instret <= r_instret + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statements can infer a latch.
  always_comb begin
    w_class = C_ILL;
    w_aluc  = 4'b0000;
    w_sext  = 1'b0;
    case (r_ir[31:26])
      6'h00: begin
        case (r_ir[5:0])
          6'h20: begin w_class = C_RALU;  w_aluc = 4'b0010; end
          6'h21: begin w_class = C_RALU;  w_aluc = 4'b0000; end
          6'h22: begin w_class = C_RALU;  w_aluc = 4'b0011; end
          6'h23: begin w_class = C_RALU;  w_aluc = 4'b0001; end
          6'h24: begin w_class = C_RALU;  w_aluc = 4'b0100; end
          6'h25: begin w_class = C_RALU;  w_aluc = 4'b0101; end
          6'h26: begin w_class = C_RALU;  w_aluc = 4'b0110; end
          6'h27: begin w_class = C_RALU;  w_aluc = 4'b0111; end
          6'h2a: begin w_class = C_RALU;  w_aluc = 4'b1011; end
          6'h2b: begin w_class = C_RALU;  w_aluc = 4'b1010; end
          6'h00: begin w_class = C_SHIFT; w_aluc = 4'b1110; end
          6'h02: begin w_class = C_SHIFT; w_aluc = 4'b1101; end
          6'h03: begin w_class = C_SHIFT; w_aluc = 4'b1100; end
          6'h08: w_class = C_JR;
          default: w_class = C_ILL;
        endcase
      end
      6'h08: begin w_class = C_IALU; w_aluc = 4'b0010; w_sext = 1'b1; end
      6'h09: begin w_class = C_IALU; w_aluc = 4'b0000; w_sext = 1'b1; end
      6'h0c: begin w_class = C_IALU; w_aluc = 4'b0100; end
      6'h0d: begin w_class = C_IALU; w_aluc = 4'b0101; end
      6'h0e: begin w_class = C_IALU; w_aluc = 4'b0110; end
      6'h0f: begin w_class = C_IALU; w_aluc = 4'b1000; end
      6'h0a: begin w_class = C_IALU; w_aluc = 4'b1011; w_sext = 1'b1; end
      6'h0b: begin w_class = C_IALU; w_aluc = 4'b1010; w_sext = 1'b1; end
      6'h23: begin w_class = C_LW;   w_aluc = 4'b0000; w_sext = 1'b1; end
      6'h2b: begin w_class = C_SW;   w_aluc = 4'b0000; w_sext = 1'b1; end
      6'h04: begin w_class = C_BEQ;  w_aluc = 4'b0001; end
      6'h05: begin w_class = C_BNE;  w_aluc = 4'b0001; end
      6'h02: w_class = C_J;
      6'h03: w_class = C_JAL;
      default: w_class = C_ILL;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: w_next_state = S_EXEC;
      S_EXEC: begin
        case (w_class)
          C_ILL:                     w_next_state = S_TRAP;
          C_LW, C_SW:                w_next_state = S_MEM;
          C_BEQ, C_BNE, C_J, C_JR:   w_next_state = S_FETCH;
          default:                   w_next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) w_next_state = (w_class == C_SW) ? S_FETCH : S_WB;
      end
      S_WB:    w_next_state = S_FETCH;
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_active = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

  always_comb begin
    {M1, M2, M3, M4, M5, M6, M7, M8, M9} = '0;
    aluc   = 4'b0000;
    sign   = 1'b0;
    if (w_active && (w_class != C_ILL)) begin
      aluc = w_aluc;
      sign = w_sext;
      M5   = 1'b1;
      case (w_class)
        C_RALU:  begin M4 = 1'b1; M6 = 1'b1; end
        C_SHIFT: begin M3 = 1'b1; M4 = 1'b1; M6 = 1'b1; end
        C_LW:    M2 = 1'b1;
        C_BEQ:   begin M4 = 1'b1; M5 = ~z; end
        C_BNE:   begin M4 = 1'b1; M5 = z; end
        C_J:     M1 = 1'b1;
        C_JAL:   begin M1 = 1'b1; M6 = 1'b1; M8 = 1'b1; M9 = 1'b1; end
        C_JR:    M7 = 1'b1;
        default: ;
      endcase
    end
  end

  // A store commits in the same cycle its acknowledge arrives.
  assign pc_ena   = ((r_state == S_EXEC) &&
                     ((w_class == C_BEQ) || (w_class == C_BNE) ||
                      (w_class == C_J)   || (w_class == C_JR))) ||
                    ((r_state == S_MEM) && (w_class == C_SW) && dmem_ack) ||
                    (r_state == S_WB);
  assign RF_W     = (r_state == S_WB);
  assign dmem_req = (r_state == S_MEM);
  assign dmem_we  = (r_state == S_MEM) && (w_class == C_SW);
  assign illegal  = (r_state == S_TRAP);
  assign state    = r_state;
  assign ir       = r_ir;
  assign Rsc      = r_ir[25:21];
  assign Rtc      = r_ir[20:16];
  assign Rdc      = r_ir[15:11];
  assign instret  = r_instret;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: expected commit records are queued when an
// instruction is driven and compared when the DUT pulses pc_ena.
module tb_cpu_ctrl_fsm;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   inst;
  logic          z;
  logic          dmem_ack;
  logic [31:0]   ir;
  logic [4:0]    Rsc, Rtc, Rdc;
  logic [3:0]    aluc;
  logic          M1, M2, M3, M4, M5, M6, M7, M8, M9;
  logic          RF_W, sign, pc_ena, dmem_req, dmem_we, illegal;
  logic [2:0]    state;
  logic [IW-1:0] instret;

  cpu_ctrl_fsm #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .inst(inst), .z(z), .dmem_ack(dmem_ack),
    .ir(ir), .Rsc(Rsc), .Rtc(Rtc), .Rdc(Rdc), .aluc(aluc),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6), .M7(M7), .M8(M8), .M9(M9),
    .RF_W(RF_W), .sign(sign), .pc_ena(pc_ena), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .illegal(illegal), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          cycles;
    logic [3:0]  aluc;
    logic [8:0]  sel;
    logic        rf_w;
    logic        sgn;
    int          req;
    logic        we;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_vec  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  int            req_cnt = 0;
  logic          we_seen = 1'b0;
  logic [IW-1:0] m_instret = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [31:0] instr, input int cycles,
                              input logic [3:0] a, input logic [8:0] sel, input logic rf_w,
                              input logic sgn, input int req, input logic we);
    exp_t e;
    e.name = name; e.instr = instr; e.cycles = cycles; e.aluc = a; e.sel = sel;
    e.rf_w = rf_w; e.sgn = sgn; e.req = req; e.we = we;
    return e;
  endfunction

  function automatic logic [31:0] strobes();
    return {13'd0, aluc, M1, M2, M3, M4, M5, M6, M7, M8, M9,
            RF_W, sign, pc_ena, dmem_req, dmem_we, illegal};
  endfunction

  // Monitor: counts cycles since FETCH and compares each commit against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      m_instret = '0;
      cyc       = 0;
    end else begin
      if (state == 3'd1) begin
        cyc = 1; req_cnt = 0; we_seen = 1'b0;
      end else begin
        cyc++;
      end
      if (dmem_req) req_cnt++;
      if (dmem_we)  we_seen = 1'b1;
      if (pc_ena) begin
        if (sb.size() == 0) begin
          check("spurious_commit", {31'd0, pc_ena}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_cycles"}, cyc, mon_e.cycles);
          check({mon_e.name, "_ir"}, ir, mon_e.instr);
          check({mon_e.name, "_regs"}, {17'd0, Rsc, Rtc, Rdc},
                {17'd0, mon_e.instr[25:21], mon_e.instr[20:16], mon_e.instr[15:11]});
          check({mon_e.name, "_aluc"}, aluc, mon_e.aluc);
          check({mon_e.name, "_sel"}, {M1, M2, M3, M4, M5, M6, M7, M8, M9}, mon_e.sel);
          check({mon_e.name, "_rfw"}, RF_W, mon_e.rf_w);
          check({mon_e.name, "_sign"}, sign, mon_e.sgn);
          check({mon_e.name, "_req"}, req_cnt, mon_e.req);
          check({mon_e.name, "_we"}, we_seen, mon_e.we);
          check({mon_e.name, "_instret"}, instret, m_instret);
          m_instret = m_instret + 1'b1;
        end
      end
    end
  end

  // Entered with the DUT in FETCH at posedge+1; returns with it in FETCH again.
  task automatic run_inst(input exp_t e, input logic zv, input int w);
    int mem_cnt = 0;
    bit done = 0;
    sb.push_back(e);
    inst = e.instr;
    z    = zv;
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1;
      if (state == 3'd3) begin
        dmem_ack = (mem_cnt == w);
        mem_cnt++;
      end else begin
        dmem_ack = 1'b0;
      end
      if (state == 3'd1) done = 1;
    end
    if (!done) check({e.name, "_timeout"}, {29'd0, state}, 32'd1);
  endtask

  task automatic run_program();
    run_inst(mk("addu",  32'h00221821, 3, 4'b0000, 9'b000111000, 1, 0, 0, 0), 0, 0);
    run_inst(mk("sub",   32'h00221822, 3, 4'b0011, 9'b000111000, 1, 0, 0, 0), 0, 0);
    run_inst(mk("sll",   32'h00021900, 3, 4'b1110, 9'b001111000, 1, 0, 0, 0), 0, 0);
    run_inst(mk("slt_r0",32'h0022002A, 3, 4'b1011, 9'b000111000, 1, 0, 0, 0), 0, 0);
    run_inst(mk("addi",  32'h2022FFFB, 3, 4'b0010, 9'b000010000, 1, 1, 0, 0), 0, 0);
    run_inst(mk("ori",   32'h34220055, 3, 4'b0101, 9'b000010000, 1, 0, 0, 0), 0, 0);
    run_inst(mk("lui",   32'h3C021234, 3, 4'b1000, 9'b000010000, 1, 0, 0, 0), 0, 0);
    run_inst(mk("lw_w2", 32'h8C220004, 6, 4'b0000, 9'b010010000, 1, 1, 3, 0), 0, 2);
    run_inst(mk("sw_w0", 32'hAC220008, 3, 4'b0000, 9'b000010000, 0, 1, 1, 1), 0, 0);
    run_inst(mk("sw_w1", 32'hAC220008, 4, 4'b0000, 9'b000010000, 0, 1, 2, 1), 0, 1);
    run_inst(mk("beq_t", 32'h1021FFFF, 2, 4'b0001, 9'b000100000, 0, 0, 0, 0), 1, 0);
    run_inst(mk("beq_n", 32'h1021FFFF, 2, 4'b0001, 9'b000110000, 0, 0, 0, 0), 0, 0);
    run_inst(mk("bne_t", 32'h14220002, 2, 4'b0001, 9'b000100000, 0, 0, 0, 0), 0, 0);
    run_inst(mk("bne_n", 32'h14220002, 2, 4'b0001, 9'b000110000, 0, 0, 0, 0), 1, 0);
    run_inst(mk("j",     32'h08000040, 2, 4'b0000, 9'b100010000, 0, 0, 0, 0), 0, 0);
    run_inst(mk("jr",    32'h03E00008, 2, 4'b0000, 9'b000010100, 0, 0, 0, 0), 0, 0);
    run_inst(mk("jal",   32'h0C000100, 3, 4'b0000, 9'b100011011, 1, 0, 0, 0), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit reached;
    reset = 1'b0; inst = 32'h0; z = 1'b0; dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_state", {29'd0, state}, 32'd0);
    end
    check("reset_strobes", strobes(), 32'd0);
    check("reset_ir", ir, 32'd0);
    check("reset_instret", {28'd0, instret}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("release_state", {29'd0, state}, 32'd1);
    check("fetch_strobes", strobes(), 32'd0);

    // Two passes so the narrow retire counter wraps.
    run_program();
    run_program();

    // Illegal opcode traps and never commits.
    inst = 32'hFC000000;
    @(posedge clk); #1;
    check("ill_exec_state", {29'd0, state}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("trap_state", {29'd0, state}, 32'd5);
    end
    check("trap_strobes", strobes(), 32'd1);
    check("trap_instret", {28'd0, instret}, {28'd0, m_instret});

    reset = 1'b0;
    @(posedge clk); #1;
    check("trap_reset_state", {29'd0, state}, 32'd0);
    check("trap_reset_strobes", strobes(), 32'd0);
    check("trap_reset_instret", {28'd0, instret}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Store aborted by reset mid-MEM, with an ack arriving alongside the reset.
    inst = 32'hAC220008;
    reached = 0;
    for (int i = 0; i < 10 && !reached; i++) begin
      @(posedge clk); #1;
      if (state == 3'd3) reached = 1;
    end
    check("abort_reach_mem", {31'd0, reached}, 32'd1);
    @(posedge clk); #1;
    check("abort_req_before", {31'd0, dmem_req}, 32'd1);
    reset = 1'b0; dmem_ack = 1'b1;
    @(posedge clk); #1;
    check("abort_req_dropped", {31'd0, dmem_req}, 32'd0);
    check("abort_state", {29'd0, state}, 32'd0);
    check("abort_instret", {28'd0, instret}, 32'd0);
    reset = 1'b1; dmem_ack = 1'b0;
    @(posedge clk); #1;
    check("abort_refetch", {29'd0, state}, 32'd1);
    run_inst(mk("addu_post", 32'h00221821, 3, 4'b0000, 9'b000111000, 1, 0, 0, 0), 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
